mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 resetn  input  1  reset, asynchronous, active-low.
REQ-003 mem_en  input  1  MEM stage holds a load/store this cycle.
REQ-004 mem_wr  input  1  1 = store, 0 = load.
REQ-005 mem_op  input  3  000 byte signed (lb/sb), 001 byte unsigned (lbu), 010 half signed (lh/sh), 011 half unsigned (lhu), 100 word (lw/sw); 101-111 reserved.
REQ-006 mem_addr  input  32  byte address.
REQ-007 mem_wdata  input  32  store data, right-aligned.
REQ-008 flush  input  1  cancel current MEM-stage instruction.
REQ-009 stall  output  1  hold pipeline.
REQ-010 load_valid  output  1  load_data valid, one-cycle pulse.
REQ-011 load_data  output  32  extended load result.
REQ-012 adel / ades  output  1 each  load / store address-alignment exception.
REQ-013 data_req, data_wr  output  1 each  SRAM-like request and write flag.
REQ-014 data_size  output  2  0 byte, 1 half, 2 word.
REQ-015 data_addr, data_wdata  output  32 each  request address and write data.
REQ-016 data_addr_ok, data_data_ok  input  1 each  request accepted / response complete.
REQ-017 data_rdata  input  32  read data, valid with data_data_ok.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-019 Misaligned: half op with addr[0]=1, or word op with addr[1:0]!=0; adel = mem_en & ~mem_wr & misaligned & ~flush; ades = same with mem_wr; both combinational.
REQ-020 IDLE: mem_en & ~flush & ~misaligned & legal op -> latch wr/op/addr/wdata, go REQ; otherwise stay IDLE.
REQ-021 data_req SHALL be 1 exactly in REQ, driven from latched values; data_addr = latched full address.
REQ-022 data_size from op[2:1]; store wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-023 REQ: data_addr_ok=0 -> stay; addr_ok=1 & data_ok=0 -> WAIT; addr_ok=1 & data_ok=1 same cycle -> DONE (rdata captured).
REQ-024 WAIT: data_ok=1 -> capture data_rdata, go DONE; otherwise stay.
REQ-025 DONE: lasts exactly one cycle, load_valid=1 if latched op is load and not cancelled; unconditionally -> IDLE, no new launch in DONE.
REQ-026 Load extraction: byte = rdata[8*addr[1:0]+7 : 8*addr[1:0]], half = rdata[16*addr[1]+15 : 16*addr[1]]; op 000/010 sign-extend, 001/011 zero-extend, 100 whole word; load_data held until next DONE.
REQ-027 stall = (IDLE & mem_en & ~flush & ~misaligned & legal op) | REQ | WAIT; stall=0 in DONE.
REQ-028 flush in REQ or WAIT SHALL NOT drop data_req before addr_ok; transaction sets cancel flag, completes normally, DONE then gives load_valid=0.
REQ-029 Reserved mem_op: no request, no stall, no exception.
REQ-030 Only one outstanding transaction at any time.

Reset
REQ-031 resetn=0 SHALL immediately force IDLE, clear cancel flag; data_req, stall, load_valid, load_data, data_addr, data_wdata, data_size, data_wr = 0.
REQ-032 Reset mid-transaction abandons it; later data_ok with state IDLE SHALL be ignored.

Verification
REQ-033 lb addr 0x1003, rdata 0x80FF_0000, addr_ok cycle 1, data_ok cycle 3 -> data_size 0, stall high 3 cycles, load_valid pulse, load_data 0xFFFF_FF80.
REQ-034 lhu addr 0x2002, rdata 0xBEEF_1234, addr_ok and data_ok same cycle -> REQ->DONE direct, load_data 0x0000_BEEF.
REQ-035 sb addr 0x10 wdata 0x0000_00A5 -> data_wr 1, data_size 0, data_wdata 0xA5A5_A5A5, load_valid 0 in DONE.
REQ-036 lw addr 0x4002 -> adel 1, data_req never 1, stall 0; sh addr 0x4001 -> ades 1.
REQ-037 lw issued, flush in WAIT, data_ok two cycles later -> stall held until DONE, load_valid 0, then IDLE.
REQ-038 resetn low during WAIT -> all outputs 0 immediately; stray data_ok after release ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store unit. Accepts one load or store from
//               the pipeline, checks alignment, and issues it as a single
//               transaction on an SRAM-like data bus. The pipeline is
//               stalled until the response arrives. Load data is extracted
//               and sign/zero-extended from the returned word. A flush
//               during a transaction lets the bus transfer complete but
//               suppresses the load result.
// Ports       : clk, resetn (async, active-low)
//               mem_en/mem_wr/mem_op/mem_addr/mem_wdata/flush - from MEM stage
//               stall, load_valid, load_data, adel, ades     - to pipeline
//               data_req/data_wr/data_size/data_addr/data_wdata - bus request
//               data_addr_ok/data_data_ok/data_rdata            - bus response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        adel,
    output logic        ades,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;

    logic        r_wr;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_cancel;
    logic [31:0] r_load_data;

    logic        w_op_legal;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_launch;
    logic        w_capture;
    logic [31:0] w_wdata_fmt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    // ------------------------------------------------------------------
    // Decode of the incoming MEM-stage request
    // ------------------------------------------------------------------
    assign w_op_legal   = (mem_op <= 3'd4);
    assign w_is_half    = (mem_op == 3'b010) || (mem_op == 3'b011);
    assign w_is_word    = (mem_op == 3'b100);
    // Reserved ops are neither half nor word, so they never raise an exception.
    assign w_misaligned = (w_is_half & mem_addr[0]) | (w_is_word & (|mem_addr[1:0]));
    assign w_launch     = mem_en & ~flush & ~w_misaligned & w_op_legal;

    assign adel = mem_en & ~mem_wr & w_misaligned & ~flush;
    assign ades = mem_en &  mem_wr & w_misaligned & ~flush;

    // Store data is replicated across the word so the slave can pick any lane.
    always_comb begin
        w_wdata_fmt = mem_wdata;
        case (mem_op[2:1])
            2'b00:   w_wdata_fmt = {4{mem_wdata[7:0]}};
            2'b01:   w_wdata_fmt = {2{mem_wdata[15:0]}};
            default: w_wdata_fmt = mem_wdata;
        endcase
    end

    // Response is taken either directly in REQ (accept and data together)
    // or later in WAIT.
    assign w_capture = ((r_state == c_ST_REQ)  & data_addr_ok & data_data_ok) |
                       ((r_state == c_ST_WAIT) & data_data_ok);

    // ------------------------------------------------------------------
    // Load-data lane extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = data_rdata[7:0];
        case (r_addr[1:0])
            2'b00:   w_byte = data_rdata[7:0];
            2'b01:   w_byte = data_rdata[15:8];
            2'b10:   w_byte = data_rdata[23:16];
            default: w_byte = data_rdata[31:24];
        endcase
        w_half = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        w_load_ext = data_rdata;
        case (r_op)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {24'd0, w_byte};
            3'b010:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b011:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = data_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_launch) w_state_next = c_ST_REQ;
            c_ST_REQ:  if (data_addr_ok) w_state_next = data_data_ok ? c_ST_DONE : c_ST_WAIT;
            c_ST_WAIT: if (data_data_ok) w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        data_req   = 1'b0;
        stall      = 1'b0;
        load_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: stall = w_launch;
            c_ST_REQ: begin
                data_req = 1'b1;
                stall    = 1'b1;
            end
            c_ST_WAIT: stall = 1'b1;
            c_ST_DONE: load_valid = ~r_wr & ~r_cancel;
            default: begin
                data_req   = 1'b0;
                stall      = 1'b0;
                load_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched request, cancel flag and load result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr        <= 1'b0;
            r_op        <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_cancel    <= 1'b0;
            r_load_data <= 32'd0;
        end else begin
            if ((r_state == c_ST_IDLE) && w_launch) begin
                r_wr     <= mem_wr;
                r_op     <= mem_op;
                r_addr   <= mem_addr;
                r_wdata  <= w_wdata_fmt;
                r_cancel <= 1'b0;
            end
            // The bus transfer cannot be withdrawn, so a flush only marks it.
            if (((r_state == c_ST_REQ) || (r_state == c_ST_WAIT)) && flush) begin
                r_cancel <= 1'b1;
            end
            // A flush arriving in the capture cycle itself also suppresses it.
            if (w_capture && !r_wr && !r_cancel && !flush) begin
                r_load_data <= w_load_ext;
            end
        end
    end

    assign load_data  = r_load_data;
    assign data_wr    = r_wr;
    assign data_size  = r_op[2:1];
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed bench for mem_access_unit with a transaction-level
//               reference model checked every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en, mem_wr, flush;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, load_valid, adel, ades;
    logic [31:0] load_data;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_op       (mem_op),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .adel         (adel),
        .ades         (ades),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int nst;

    // Transaction-level model: an outstanding transfer, whether the slave
    // has accepted it, and whether this is the completion cycle.
    bit          m_active, m_acc, m_fin, m_cancel;
    logic        tx_wr;
    logic [2:0]  tx_op;
    logic [31:0] tx_addr, tx_wdata, m_ld;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int op_bytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 1;
            3'd2, 3'd3: return 2;
            3'd4:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit misal(input logic [2:0] op, input logic [31:0] addr);
        int b = op_bytes(op);
        return (b > 1) && ((int'(addr[1:0]) % b) != 0);
    endfunction

    function automatic logic [31:0] fmt_store(input logic [2:0] op, input logic [31:0] w);
        int b = op_bytes(op);
        logic [31:0] r = 32'd0;
        if (b == 0) return 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % b) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * int'(addr[1:0]));
        int b = op_bytes(op);
        if (b == 1) begin
            v = v & 32'h0000_00FF;
            if (op == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (b == 2) begin
            v = v & 32'h0000_FFFF;
            if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [1:0] exp_size(input logic [2:0] op);
        int b = op_bytes(op);
        return (b == 4) ? 2'd2 : (b == 2) ? 2'd1 : 2'd0;
    endfunction

    task automatic m_reset;
        m_active = 0; m_acc = 0; m_fin = 0; m_cancel = 0;
        tx_wr = 0; tx_op = 0; tx_addr = 0; tx_wdata = 0; m_ld = 0;
    endtask

    task automatic check_all;
        bit mis    = misal(mem_op, mem_addr);
        bit launch = mem_en && !flush && (op_bytes(mem_op) != 0) && !mis;
        chk1 ("stall",      stall,      m_active || (!m_fin && launch));
        chk1 ("data_req",   data_req,   m_active && !m_acc);
        chk1 ("load_valid", load_valid, m_fin && !tx_wr && !m_cancel);
        chk1 ("adel",       adel,       mem_en && !mem_wr && mis && !flush);
        chk1 ("ades",       ades,       mem_en &&  mem_wr && mis && !flush);
        chk1 ("data_wr",    data_wr,    tx_wr);
        chk32("data_size",  {30'd0, data_size}, {30'd0, exp_size(tx_op)});
        chk32("data_addr",  data_addr,  tx_addr);
        chk32("data_wdata", data_wdata, fmt_store(tx_op, tx_wdata));
        chk32("load_data",  load_data,  m_ld);
    endtask

    task automatic model_update;
        if (!resetn) begin
            m_reset();
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_active) begin
            if (flush) m_cancel = 1;
            if ((!m_acc && data_addr_ok && data_data_ok) || (m_acc && data_data_ok)) begin
                m_active = 0; m_acc = 0; m_fin = 1;
                if (!tx_wr && !m_cancel) m_ld = extract(tx_op, tx_addr, data_rdata);
            end else if (!m_acc && data_addr_ok) begin
                m_acc = 1;
            end
        end else if (mem_en && !flush && op_bytes(mem_op) != 0 && !misal(mem_op, mem_addr)) begin
            m_active = 1; m_cancel = 0;
            tx_wr = mem_wr; tx_op = mem_op; tx_addr = mem_addr; tx_wdata = mem_wdata;
        end
    endtask

    // Compare at the falling edge, advance the model with the inputs the DUT
    // is about to sample, then return just after the rising edge.
    task automatic step;
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        mem_en = 0; mem_wr = 0; mem_op = 0; mem_addr = 0; mem_wdata = 0; flush = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    endtask

    task automatic ld(input logic [2:0] op, input logic [31:0] addr);
        mem_en = 1; mem_wr = 0; mem_op = op; mem_addr = addr;
    endtask

    initial begin
        clr();
        resetn = 0;
        m_reset();
        step();
        chk1 ("rst stall",     stall, 1'b0);
        chk1 ("rst data_req",  data_req, 1'b0);
        chk32("rst load_data", load_data, 32'd0);
        step();
        resetn = 1;
        step();

        // lb 0x1003, accept in REQ, data one cycle later
        ld(3'd0, 32'h0000_1003);
        #1; nst = int'(stall);
        step();
        chk1 ("lb req", data_req, 1'b1);
        chk32("lb size", {30'd0, data_size}, 32'd0);
        chk32("lb addr", data_addr, 32'h0000_1003);
        nst += int'(stall);
        data_addr_ok = 1;
        step();
        nst += int'(stall);
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h80FF_0000;
        step();
        chk1 ("lb valid", load_valid, 1'b1);
        chk32("lb data", load_data, 32'hFFFF_FF80);
        chk1 ("lb done stall", stall, 1'b0);
        chk32("lb stall cycles", nst, 32'd3);
        clr();
        step();
        chk32("lb held", load_data, 32'hFFFF_FF80);

        // lhu 0x2002, accept and data together
        ld(3'd3, 32'h0000_2002);
        step();
        data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hBEEF_1234;
        step();
        chk1 ("lhu valid", load_valid, 1'b1);
        chk32("lhu data", load_data, 32'h0000_BEEF);
        clr();
        step();

        // sb 0x10
        mem_en = 1; mem_wr = 1; mem_op = 3'd0; mem_addr = 32'h10; mem_wdata = 32'h0000_00A5;
        step();
        chk1 ("sb wr", data_wr, 1'b1);
        chk32("sb wdata", data_wdata, 32'hA5A5_A5A5);
        data_addr_ok = 1; data_data_ok = 1;
        step();
        chk1 ("sb valid", load_valid, 1'b0);
        clr();
        step();

        // lh 0x0006 with slave holding off accept for two cycles
        ld(3'd2, 32'h0000_0006);
        step(); step(); step();
        chk1("lh req held", data_req, 1'b1);
        data_addr_ok = 1;
        step();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h8001_7FFF;
        step();
        chk32("lh data", load_data, 32'hFFFF_8001);
        clr();
        step();

        // Misaligned and reserved ops
        ld(3'd4, 32'h0000_4002);
        #1;
        chk1("lw adel", adel, 1'b1);
        chk1("lw adel stall", stall, 1'b0);
        step();
        chk1("lw adel no req", data_req, 1'b0);
        mem_wr = 1; mem_op = 3'd2; mem_addr = 32'h0000_4001;
        #1;
        chk1("sh ades", ades, 1'b1);
        step();
        flush = 1;
        step();
        mem_wr = 0; mem_op = 3'd5; flush = 0;
        #1;
        chk1("rsv stall", stall, 1'b0);
        step();
        chk1("rsv no req", data_req, 1'b0);
        clr();
        step();

        // lw with flush in WAIT, data two cycles later
        ld(3'd4, 32'h0000_3000);
        step();
        data_addr_ok = 1;
        step();
        data_addr_ok = 0; flush = 1;
        step();
        flush = 0;
        chk1("flush wait stall", stall, 1'b1);
        step();
        data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
        step();
        chk1 ("flush valid", load_valid, 1'b0);
        chk1 ("flush done stall", stall, 1'b0);
        chk32("flush keeps data", load_data, 32'hFFFF_8001);
        clr();
        step();
        chk1("flush idle stall", stall, 1'b0);

        // Flush in REQ must not withdraw the request
        ld(3'd2, 32'h0000_5002);
        step();
        flush = 1;
        step();
        chk1("flush req kept", data_req, 1'b1);
        flush = 0; data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1111_2222;
        step();
        chk1("flush req valid", load_valid, 1'b0);
        clr();
        step();

        // Flush in IDLE blocks the launch
        ld(3'd4, 32'h0000_8000); flush = 1;
        #1;
        chk1("flush idle no stall", stall, 1'b0);
        step();
        clr();
        step();

        // sh 0x6002 through WAIT
        mem_en = 1; mem_wr = 1; mem_op = 3'd2; mem_addr = 32'h0000_6002; mem_wdata = 32'h1234_BEEF;
        step();
        chk32("sh wdata", data_wdata, 32'hBEEF_BEEF);
        data_addr_ok = 1;
        step();
        data_addr_ok = 0; data_data_ok = 1;
        step();
        clr();
        step();

        // Reset during WAIT, then a stray response
        ld(3'd4, 32'h0000_7000); mem_wdata = 32'h1234_5678;
        step();
        data_addr_ok = 1;
        step();
        clr();
        resetn = 0;
        #1;
        chk1 ("rstw stall",  stall, 1'b0);
        chk1 ("rstw req",    data_req, 1'b0);
        chk32("rstw ldata",  load_data, 32'd0);
        chk32("rstw addr",   data_addr, 32'd0);
        chk32("rstw wdata",  data_wdata, 32'd0);
        chk32("rstw size",   {30'd0, data_size}, 32'd0);
        m_reset();
        step();
        resetn = 1; data_data_ok = 1; data_rdata = 32'hFFFF_FFFF;
        step();
        chk1 ("stray valid", load_valid, 1'b0);
        chk32("stray ldata", load_data, 32'd0);
        clr();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
